// File: rtl/siso_word_ctrl.sv
// Word-level serializer/deserializer around an external SISO delay line.
// Optional build macro SISO_CTRL_CHECK_EN adds a shadow-word compare driving err.
//
// state | meaning
// IDLE  | waiting for a word; in_ready when SISO is out of reset and no abort
// SHIFT | WIDTH cycles driving the buffered word MSB first into the SISO
// DRAIN | DEPTH cycles of zero padding while the tail of the word emerges
// DONE  | one-cycle out_valid with the reassembled word
module siso_word_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock_in,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             abort,
  output logic             sr_serial_in,
  input  logic             sr_serial_out,
  output logic             sr_resetn,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + DEPTH);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(WIDTH + DEPTH - 1);
  localparam logic [CW-1:0] CAP_START  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_buf_q, shift_buf_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             sr_serial_in_q, sr_serial_in_d;
  logic             sr_resetn_q, sr_resetn_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] cap_shift;
  logic             cap_en;
`ifdef SISO_CTRL_CHECK_EN
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             err_q, err_d;
`endif

  // Bits from the SISO land in the capture LSB; the oldest bit ends at the MSB.
  assign cap_shift = WIDTH'({cap_q, sr_serial_out});
  assign cap_en    = ((state_q == SHIFT) || (state_q == DRAIN)) && (cnt_q >= CAP_START);
  assign in_ready  = (state_q == IDLE) && sr_resetn_q && !abort;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_buf_d    = shift_buf_q;
    cap_d          = cap_q;
    out_data_d     = out_data_q;
    out_valid_d    = 1'b0;
    sr_serial_in_d = 1'b0;
    sr_resetn_d    = !abort;
`ifdef SISO_CTRL_CHECK_EN
    shadow_d       = shadow_q;
    err_d          = 1'b0;
`endif
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      if (cap_en) cap_d = cap_shift;
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            state_d        = SHIFT;
            cnt_d          = '0;
            sr_serial_in_d = in_data[WIDTH-1];
            shift_buf_d    = in_data << 1;
            cap_d          = '0;
`ifdef SISO_CTRL_CHECK_EN
            shadow_d       = in_data;
`endif
          end
        end
        SHIFT: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_SHIFT) begin
            state_d = DRAIN;
          end else begin
            sr_serial_in_d = shift_buf_q[WIDTH-1];
            shift_buf_d    = shift_buf_q << 1;
          end
        end
        DRAIN: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_DRAIN) begin
            // Last capture happens this cycle, so publish the shifted value directly.
            state_d     = DONE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = cap_shift;
`ifdef SISO_CTRL_CHECK_EN
            err_d       = (cap_shift != shadow_q);
`endif
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock_in) begin
    if (!resetn) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_buf_q    <= '0;
      cap_q          <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      sr_serial_in_q <= 1'b0;
      sr_resetn_q    <= 1'b0;
      busy_q         <= 1'b0;
`ifdef SISO_CTRL_CHECK_EN
      shadow_q       <= '0;
      err_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_buf_q    <= shift_buf_d;
      cap_q          <= cap_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      sr_serial_in_q <= sr_serial_in_d;
      sr_resetn_q    <= sr_resetn_d;
      busy_q         <= busy_d;
`ifdef SISO_CTRL_CHECK_EN
      shadow_q       <= shadow_d;
      err_q          <= err_d;
`endif
    end
  end

  assign sr_serial_in = sr_serial_in_q;
  assign sr_resetn    = sr_resetn_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = busy_q;
`ifdef SISO_CTRL_CHECK_EN
  assign err          = err_q;
`else
  assign err          = 1'b0;
`endif

endmodule
